// File: rtl/serial_frame_checker.sv
// Deserializes an LSB-first bit stream into frames and checks them for thermometer codes.
// Optional level-sequence tracking is built only when CHECK_SEQUENCE_EN is defined.
module serial_frame_checker #(
   parameter int FRAME_W     = 8,
   parameter int LVL_W       = 4,
   parameter int ERR_W       = 8,
   parameter int LOCK_FRAMES = 2
) (
   input  logic               CLK,
   input  logic               CLEAR_N,
   input  logic               BIT_IN,
   input  logic               BIT_EN,
   input  logic               FRAME_START,
   output logic [FRAME_W-1:0] BYTE_OUT,
   output logic               BYTE_VALID,
   output logic [LVL_W-1:0]   LEVEL,
   output logic               CODE_ERR,
   output logic               SEQ_ERR,
   output logic [ERR_W-1:0]   ERR_COUNT,
   output logic               LOCKED
);

   localparam int IDX_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
   localparam int CLEAN_W = 4;

   typedef enum logic [1:0] {S_HUNT, S_SHIFT, S_REPORT} state_t;

   state_t               r_state;
   logic [IDX_W-1:0]     r_idx;
   logic [FRAME_W-1:0]   r_shift;
   logic [FRAME_W-1:0]   r_byte_out;
   logic                 r_byte_valid;
   logic [LVL_W-1:0]     r_level;
   logic                 r_code_err;
   logic                 r_seq_err;
   logic [ERR_W-1:0]     r_err_count;
   logic                 r_locked;
   logic [CLEAN_W-1:0]   r_clean;
`ifdef CHECK_SEQUENCE_EN
   logic [LVL_W-1:0]     r_prev_level;
   logic                 r_ref_valid;
`endif

   logic                 w_start;
   logic [FRAME_W-1:0]   w_frame;
   logic [FRAME_W:0]     w_frame_ext;
   logic                 w_legal;
   logic [LVL_W-1:0]     w_popcnt;
   logic [LVL_W-1:0]     w_level;
   logic                 w_seq_bad;
   logic [ERR_W-1:0]     w_err_sat;
   logic [CLEAN_W-1:0]   w_clean_next;

   assign w_start     = BIT_EN & FRAME_START;
   // The frame as it would look with the current bit merged in; used for both shifting and checking.
   assign w_frame     = r_shift | (FRAME_W'(BIT_IN) << r_idx);
   assign w_frame_ext = {1'b0, w_frame};
   assign w_legal     = (w_frame != '0) &&
                        ((w_frame_ext & (w_frame_ext + {{FRAME_W{1'b0}}, 1'b1})) == '0);

   always_comb begin
      w_popcnt = '0;
      for (int i = 0; i < FRAME_W; i++) begin
         w_popcnt = w_popcnt + LVL_W'(w_frame[i]);
      end
   end

   assign w_level      = w_legal ? w_popcnt : '0;
   assign w_err_sat    = (r_err_count == {ERR_W{1'b1}}) ? r_err_count : r_err_count + ERR_W'(1);
   assign w_clean_next = (r_clean == CLEAN_W'(LOCK_FRAMES)) ? r_clean : r_clean + CLEAN_W'(1);

`ifdef CHECK_SEQUENCE_EN
   assign w_seq_bad = w_legal && r_ref_valid &&
                      !((w_level == r_prev_level) ||
                        (w_level == r_prev_level + LVL_W'(1)) ||
                        ((r_prev_level == LVL_W'(FRAME_W)) && (w_level == LVL_W'(1))));
`else
   assign w_seq_bad = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (!CLEAR_N) begin
         r_state      <= S_HUNT;
         r_idx        <= '0;
         r_shift      <= '0;
         r_byte_out   <= '0;
         r_byte_valid <= 1'b0;
         r_level      <= '0;
         r_code_err   <= 1'b0;
         r_seq_err    <= 1'b0;
         r_err_count  <= '0;
         r_locked     <= 1'b0;
         r_clean      <= '0;
`ifdef CHECK_SEQUENCE_EN
         r_prev_level <= '0;
         r_ref_valid  <= 1'b0;
`endif
      end else begin
         r_byte_valid <= 1'b0;
         case (r_state)
            S_HUNT: begin
               if (w_start) begin
                  r_shift <= FRAME_W'(BIT_IN);
                  r_idx   <= IDX_W'(1);
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (BIT_EN) begin
                  if (FRAME_START && (r_idx != '0)) begin
                     // Strobe inside a frame: drop the partial frame and restart from this bit.
                     r_shift     <= FRAME_W'(BIT_IN);
                     r_idx       <= IDX_W'(1);
                     r_err_count <= w_err_sat;
                     r_locked    <= 1'b0;
                     r_clean     <= '0;
`ifdef CHECK_SEQUENCE_EN
                     r_ref_valid <= 1'b0;
`endif
                  end else if (r_idx == IDX_W'(FRAME_W - 1)) begin
                     r_byte_out   <= w_frame;
                     r_level      <= w_level;
                     r_code_err   <= !w_legal;
                     r_seq_err    <= w_seq_bad;
                     r_byte_valid <= 1'b1;
                     r_shift      <= '0;
                     r_idx        <= '0;
                     r_state      <= S_REPORT;
                     if (!w_legal || w_seq_bad) begin
                        r_err_count <= w_err_sat;
                        r_locked    <= 1'b0;
                        r_clean     <= '0;
`ifdef CHECK_SEQUENCE_EN
                        r_ref_valid <= 1'b0;
`endif
                     end else begin
                        r_clean  <= w_clean_next;
                        r_locked <= (w_clean_next == CLEAN_W'(LOCK_FRAMES));
`ifdef CHECK_SEQUENCE_EN
                        r_prev_level <= w_level;
                        r_ref_valid  <= 1'b1;
`endif
                     end
                  end else begin
                     r_shift <= w_frame;
                     r_idx   <= r_idx + IDX_W'(1);
                  end
               end
            end
            S_REPORT: begin
               // A bit arriving here already belongs to the next frame, strobed or not.
               r_state <= S_SHIFT;
               if (BIT_EN) begin
                  r_shift <= FRAME_W'(BIT_IN);
                  r_idx   <= IDX_W'(1);
               end else begin
                  r_shift <= '0;
                  r_idx   <= '0;
               end
            end
            default: begin
               r_state <= S_HUNT;
               r_idx   <= '0;
               r_shift <= '0;
            end
         endcase
      end
   end

   assign BYTE_OUT   = r_byte_out;
   assign BYTE_VALID = r_byte_valid;
   assign LEVEL      = r_level;
   assign CODE_ERR   = r_code_err;
   assign SEQ_ERR    = r_seq_err;
   assign ERR_COUNT  = r_err_count;
   assign LOCKED     = r_locked;

endmodule

// File: tb/tb_serial_frame_checker.sv
// Self-checking bench for serial_frame_checker: directed scenarios plus randomized stream
// against a frame-level reference model (bit queue + thermometer lookup).
module tb_serial_frame_checker;

   localparam int FW = 8;
   localparam int LW = 4;
   localparam int EW = 8;
   localparam int LF = 2;

   logic          CLK = 1'b0;
   logic          CLEAR_N = 1'b0;
   logic          BIT_IN = 1'b0;
   logic          BIT_EN = 1'b0;
   logic          FRAME_START = 1'b0;
   logic [FW-1:0] BYTE_OUT;
   logic          BYTE_VALID;
   logic [LW-1:0] LEVEL;
   logic          CODE_ERR;
   logic          SEQ_ERR;
   logic [EW-1:0] ERR_COUNT;
   logic          LOCKED;

   serial_frame_checker #(.FRAME_W(FW), .LVL_W(LW), .ERR_W(EW), .LOCK_FRAMES(LF)) dut (
      .CLK(CLK), .CLEAR_N(CLEAR_N), .BIT_IN(BIT_IN), .BIT_EN(BIT_EN),
      .FRAME_START(FRAME_START), .BYTE_OUT(BYTE_OUT), .BYTE_VALID(BYTE_VALID),
      .LEVEL(LEVEL), .CODE_ERR(CODE_ERR), .SEQ_ERR(SEQ_ERR),
      .ERR_COUNT(ERR_COUNT), .LOCKED(LOCKED)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   // Reference model state
   bit            m_hunt = 1'b1;
   bit            m_bits[$];
   int            m_clean = 0;
   int            m_prev = 0;
   bit            m_ref = 1'b0;
   logic [FW-1:0] exp_byte = '0;
   logic          exp_valid = 1'b0;
   logic [LW-1:0] exp_level = '0;
   logic          exp_code = 1'b0;
   logic          exp_seq = 1'b0;
   logic [EW-1:0] exp_err = '0;
   logic          exp_locked = 1'b0;

   wire [23:0] dut_vec = {BYTE_OUT, BYTE_VALID, LEVEL, CODE_ERR, SEQ_ERR, ERR_COUNT, LOCKED};
   wire [23:0] exp_vec = {exp_byte, exp_valid, exp_level, exp_code, exp_seq, exp_err, exp_locked};

   task automatic model_error();
      if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
      m_clean    = 0;
      exp_locked = 1'b0;
      m_ref      = 1'b0;
   endtask

   task automatic model_judge();
      int  val = 0;
      int  k = 0;
      bit  s = 1'b0;
      for (int i = 0; i < FW; i++) val += int'(m_bits[i]) << i;
      for (int j = 1; j <= FW; j++) if (val == (1 << j) - 1) k = j;
`ifdef CHECK_SEQUENCE_EN
      s = (k != 0) && m_ref && !(k == m_prev || k == m_prev + 1 || (m_prev == FW && k == 1));
`endif
      exp_byte  = FW'(val);
      exp_level = LW'(k);
      exp_code  = (k == 0);
      exp_seq   = s;
      exp_valid = 1'b1;
      if (k == 0 || s) begin
         model_error();
      end else begin
         if (m_clean < LF) m_clean++;
         exp_locked = (m_clean == LF);
         m_prev     = k;
         m_ref      = 1'b1;
      end
   endtask

   task automatic model_edge(input logic clr, input logic en, input logic b, input logic fs);
      exp_valid = 1'b0;
      if (!clr) begin
         m_hunt = 1'b1; m_bits.delete(); m_clean = 0; m_prev = 0; m_ref = 1'b0;
         exp_byte = '0; exp_level = '0; exp_code = 1'b0; exp_seq = 1'b0;
         exp_err = '0; exp_locked = 1'b0;
      end else if (en) begin
         if (m_hunt) begin
            if (fs) begin
               m_hunt = 1'b0; m_bits.delete(); m_bits.push_back(b);
            end
         end else if (fs && m_bits.size() != 0) begin
            model_error();
            m_bits.delete(); m_bits.push_back(b);
         end else begin
            m_bits.push_back(b);
            if (m_bits.size() == FW) begin
               model_judge();
               m_bits.delete();
            end
         end
      end
   endtask

   task automatic step(input logic clr, input logic en, input logic b, input logic fs);
      CLEAR_N = clr; BIT_EN = en; BIT_IN = b; FRAME_START = fs;
      @(posedge CLK);
      model_edge(clr, en, b, fs);
      #1;
      if (BYTE_VALID)
         $display("frame byte=0x%02h level=%0d code_err=%0b seq_err=%0b err_count=%0d locked=%0b",
                  BYTE_OUT, LEVEL, CODE_ERR, SEQ_ERR, ERR_COUNT, LOCKED);
   endtask

   task automatic drive_frame(input logic [FW-1:0] v, input logic fs_first);
      for (int i = 0; i < FW; i++) step(1'b1, 1'b1, v[i], fs_first && (i == 0));
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1);
         total++;
         if (dut_vec !== 24'h0) begin
            bad++; $display("FAIL reset_outputs: got %h want 000000", dut_vec);
         end
      end
   endtask

   task automatic test_first_frame();
      drive_frame(8'h07, 1'b1);
      total++; if (BYTE_VALID !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", BYTE_VALID); end
      total++; if (BYTE_OUT !== 8'h07) begin bad++; $display("FAIL first_byte: got %h want 07", BYTE_OUT); end
      total++; if (LEVEL !== 4'd3) begin bad++; $display("FAIL first_level: got %0d want 3", LEVEL); end
      total++; if (CODE_ERR !== 1'b0) begin bad++; $display("FAIL first_code_err: got %b want 0", CODE_ERR); end
      total++; if (ERR_COUNT !== 8'd0) begin bad++; $display("FAIL first_err_count: got %0d want 0", ERR_COUNT); end
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (dut_vec !== exp_vec || BYTE_VALID !== 1'b0 || BYTE_OUT !== 8'h07) begin
         bad++; $display("FAIL first_hold: got %h want %h", dut_vec, exp_vec);
      end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int first_c = -1;
      int last_c = -1;
      for (int c = 0; c < 2 * FW; c++) begin
         step(1'b1, 1'b1, (c % FW) == 0, (c % FW) == 0);
         if (BYTE_VALID === 1'b1) begin
            pulses++;
            if (first_c < 0) first_c = c;
            last_c = c;
            total++;
            if (LEVEL !== 4'd1) begin bad++; $display("FAIL b2b_level: got %0d want 1", LEVEL); end
         end
      end
      total++; if (pulses != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      total++; if (last_c - first_c != FW) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", last_c - first_c, FW); end
      total++; if (LOCKED !== 1'b1) begin bad++; $display("FAIL b2b_locked: got %b want 1", LOCKED); end
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL b2b_model: got %h want %h", dut_vec, exp_vec); end
   endtask

   task automatic test_code_err();
      logic [EW-1:0] e0 = exp_err;
      drive_frame(8'h05, 1'b1);
      total++; if (LEVEL !== 4'd0) begin bad++; $display("FAIL illegal_level: got %0d want 0", LEVEL); end
      total++; if (CODE_ERR !== 1'b1) begin bad++; $display("FAIL illegal_code_err: got %b want 1", CODE_ERR); end
      total++; if (ERR_COUNT !== e0 + 8'd1) begin bad++; $display("FAIL illegal_err_count: got %0d want %0d", ERR_COUNT, e0 + 8'd1); end
      total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL illegal_locked: got %b want 0", LOCKED); end
      drive_frame(8'hFF, 1'b1);
      total++; if (LEVEL !== 4'd8) begin bad++; $display("FAIL full_level: got %0d want 8", LEVEL); end
      total++; if (CODE_ERR !== 1'b0) begin bad++; $display("FAIL full_code_err: got %b want 0", CODE_ERR); end
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL full_model: got %h want %h", dut_vec, exp_vec); end
   endtask

   task automatic test_framing();
      logic [EW-1:0] e0 = exp_err;
      logic [FW-1:0] v = 8'h0F;
      for (int c = 0; c < 3 + FW; c++) begin
         if (c < 3) step(1'b1, 1'b1, 1'b1, c == 0);
         else       step(1'b1, 1'b1, v[c - 3], c == 3);
         if (c < 2 + FW) begin
            total++;
            if (BYTE_VALID !== 1'b0) begin bad++; $display("FAIL framing_no_valid: got %b want 0 at cycle %0d", BYTE_VALID, c); end
         end
         if (c == 3) begin
            total++;
            if (ERR_COUNT !== e0 + 8'd1) begin bad++; $display("FAIL framing_err_count: got %0d want %0d", ERR_COUNT, e0 + 8'd1); end
         end
      end
      total++; if (BYTE_VALID !== 1'b1) begin bad++; $display("FAIL framing_valid: got %b want 1", BYTE_VALID); end
      total++; if (BYTE_OUT !== 8'h0F) begin bad++; $display("FAIL framing_byte: got %h want 0f", BYTE_OUT); end
      total++; if (LEVEL !== 4'd4) begin bad++; $display("FAIL framing_level: got %0d want 4", LEVEL); end
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL framing_model: got %h want %h", dut_vec, exp_vec); end
   endtask

   task automatic test_midframe_reset();
      for (int c = 0; c < 5; c++) step(1'b1, 1'b1, 1'b1, c == 0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      total++; if (dut_vec !== 24'h0) begin bad++; $display("FAIL midreset_outputs: got %h want 000000", dut_vec); end
      for (int c = 0; c < 2 * FW + 2; c++) begin
         step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         total++;
         if (BYTE_VALID !== 1'b0) begin bad++; $display("FAIL hunt_no_valid: got %b want 0 at cycle %0d", BYTE_VALID, c); end
      end
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL hunt_model: got %h want %h", dut_vec, exp_vec); end
   endtask

   task automatic test_sequence();
      logic [FW-1:0] codes [4] = '{8'h7F, 8'hFF, 8'h01, 8'h07};
      logic [3:0]    seq_want;
      logic [EW-1:0] err_want;
`ifdef CHECK_SEQUENCE_EN
      seq_want = 4'b1000; err_want = 8'd1;
`else
      seq_want = 4'b0000; err_want = 8'd0;
`endif
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int f = 0; f < 4; f++) begin
         drive_frame(codes[f], f == 0);
         total++;
         if (SEQ_ERR !== seq_want[f]) begin bad++; $display("FAIL seq_err_frame%0d: got %b want %b", f, SEQ_ERR, seq_want[f]); end
      end
      total++; if (ERR_COUNT !== err_want) begin bad++; $display("FAIL seq_err_count: got %0d want %0d", ERR_COUNT, err_want); end
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL seq_model: got %h want %h", dut_vec, exp_vec); end
   endtask

   task automatic test_random();
      for (int f = 0; f < 60; f++) begin
         logic [FW-1:0] v;
         if ($urandom_range(0, 9) < 6) v = FW'((1 << $urandom_range(1, FW)) - 1);
         else                          v = FW'($urandom_range(0, 255));
         for (int i = 0; i < FW; i++) begin
            int gaps = $urandom_range(0, 1);
            for (int g = 0; g <= gaps; g++) begin
               logic en  = (g == gaps);
               logic clr = ($urandom_range(0, 150) != 0);
               logic fs;
               if (!en)         fs = 1'($urandom_range(0, 1));
               else if (i == 0) fs = ($urandom_range(0, 3) != 0);
               else             fs = ($urandom_range(0, 30) == 0);
               step(clr, en, en ? v[i] : 1'($urandom_range(0, 1)), fs);
               total++;
               if (dut_vec !== exp_vec) begin bad++; $display("FAIL random_f%0d_b%0d: got %h want %h", f, i, dut_vec, exp_vec); end
            end
         end
      end
   endtask

   task automatic test_saturation();
      for (int c = 0; c < 300; c++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
      total++; if (ERR_COUNT !== 8'hFF) begin bad++; $display("FAIL sat_err_count: got %0d want 255", ERR_COUNT); end
      total++; if (dut_vec !== exp_vec) begin bad++; $display("FAIL sat_model: got %h want %h", dut_vec, exp_vec); end
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (dut_vec !== 24'h0) begin bad++; $display("FAIL sat_reset: got %h want 000000", dut_vec); end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_back_to_back();
      test_code_err();
      test_framing();
      test_midframe_reset();
      test_sequence();
      test_random();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
